// File: rtl/iir_pkg.sv
// Shared state encoding, default widths and the output-history saturation helper
// for the time-multiplexed IIR section.
package iir_pkg;

  localparam int unsigned ACC_W      = 64;
  localparam int unsigned DIN_W      = 8;
  localparam int unsigned COEF_W_DEF = 16;
  localparam int unsigned FRAC_DEF   = 13;
  localparam int unsigned Y_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Floor-rounded arithmetic shift by frac, clamped to a y_w-bit signed range.
  function automatic logic signed [ACC_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] acc,
    input int unsigned             frac,
    input int unsigned             y_w
  );
    logic signed [ACC_W-1:0] sh;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (y_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (y_w - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Shared multiply-accumulate: one registered multiplier stage feeding a 64-bit
// accumulator that adds or subtracts the registered product.
module iir_mac_unit
  import iir_pkg::*;
#(
  parameter int unsigned A_W = 16,
  parameter int unsigned B_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    mul_en,
  input  logic                    sub,
  input  logic                    acc_en,
  input  logic signed [A_W-1:0]   coef,
  input  logic signed [B_W-1:0]   operand,
  output logic signed [ACC_W-1:0] acc_next_c
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic                    prod_sub;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext   = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
  assign acc_next_c = prod_sub ? (acc - prod_ext) : (acc + prod_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod     <= '0;
      prod_sub <= 1'b0;
    end else if (mul_en) begin
      prod     <= P_W'(coef) * P_W'(operand);
      prod_sub <= sub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr)  acc <= '0;
    else if (acc_en) acc <= acc_next_c;
  end

endmodule

// File: rtl/iir_mac_sequencer.sv
// Direct-form-I IIR section sequencer: one tap per cycle through a shared MAC,
// coefficients fetched from a 1-cycle-latency external memory.
module iir_mac_sequencer
  import iir_pkg::*;
#(
  parameter int unsigned NB     = 3,
  parameter int unsigned NA     = 2,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int unsigned Y_W    = Y_W_DEF,
  localparam int unsigned NT    = NB + NA,
  localparam int unsigned AW    = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DIN_W-1:0] data_in,
  input  logic                    clr,
  output logic [AW-1:0]           coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] data_out,
  output logic                    busy
);

  state_e                  state, state_d;
  logic [AW-1:0]           coef_addr_d;
  logic                    in_ready_d, out_valid_d, busy_d;
  logic signed [ACC_W-1:0] data_out_d;
  logic signed [DIN_W-1:0] x_hist [NB];
  logic signed [DIN_W-1:0] x_d    [NB];
  logic signed [Y_W-1:0]   y_hist [NA];
  logic signed [Y_W-1:0]   y_d    [NA];

  // Pipeline: b = coefficient arriving from memory, c = product registered in MAC.
  logic                    vld_b, vld_b_d, last_b, last_b_d;
  logic [AW-1:0]           idx_b, idx_b_d;
  logic                    vld_c, last_c;
  logic                    acc_clr_c, sub_c;
  logic signed [Y_W-1:0]   operand_c;
  logic signed [ACC_W-1:0] acc_next_c;

  // History operand aligned with the coefficient now on coef_data.
  always_comb begin
    operand_c = '0;
    for (int k = 0; k < int'(NB); k++)
      if (idx_b == AW'(k)) operand_c = Y_W'(x_hist[k]);
    for (int j = 0; j < int'(NA); j++)
      if (idx_b == AW'(NB + j)) operand_c = y_hist[j];
  end

  assign sub_c = (idx_b >= AW'(NB));

  iir_mac_unit #(.A_W(COEF_W), .B_W(Y_W)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr        (acc_clr_c),
    .mul_en     (vld_b),
    .sub        (sub_c),
    .acc_en     (vld_c),
    .coef       (coef_data),
    .operand    (operand_c),
    .acc_next_c (acc_next_c)
  );

  always_comb begin
    state_d     = state;
    coef_addr_d = coef_addr;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    busy_d      = busy;
    data_out_d  = data_out;
    x_d         = x_hist;
    y_d         = y_hist;
    vld_b_d     = 1'b0;
    last_b_d    = 1'b0;
    idx_b_d     = idx_b;
    acc_clr_c   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d[0] = data_in;
          for (int i = int'(NB) - 1; i > 0; i--) x_d[i] = x_hist[i-1];
          acc_clr_c   = 1'b1;
          coef_addr_d = '0;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end else if (clr) begin
          for (int i = 0; i < int'(NB); i++) x_d[i] = '0;
          for (int i = 0; i < int'(NA); i++) y_d[i] = '0;
        end
      end
      RUN: begin
        vld_b_d  = 1'b1;
        idx_b_d  = coef_addr;
        last_b_d = (coef_addr == AW'(NT - 1));
        if (coef_addr == AW'(NT - 1)) state_d = DRAIN;
        else coef_addr_d = coef_addr + AW'(1);
      end
      DRAIN: begin
        if (vld_c && last_c) begin
          data_out_d  = acc_next_c;
          y_d[0]      = Y_W'(sat_shift(acc_next_c, FRAC, Y_W));
          for (int i = int'(NA) - 1; i > 0; i--) y_d[i] = y_hist[i-1];
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      coef_addr <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      x_hist    <= '{default: '0};
      y_hist    <= '{default: '0};
      vld_b     <= 1'b0;
      last_b    <= 1'b0;
      idx_b     <= '0;
      vld_c     <= 1'b0;
      last_c    <= 1'b0;
    end else begin
      state     <= state_d;
      coef_addr <= coef_addr_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      data_out  <= data_out_d;
      x_hist    <= x_d;
      y_hist    <= y_d;
      vld_b     <= vld_b_d;
      last_b    <= last_b_d;
      idx_b     <= idx_b_d;
      vld_c     <= vld_b;
      last_c    <= last_b;
    end
  end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Scoreboard bench for iir_mac_sequencer: a difference-equation model predicts each
// result on accept; an independent monitor checks results, latency and handshakes.
module tb_iir_mac_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  data_in;
  logic               clr;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [63:0] data_out;
  logic               busy;

  iir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .clr       (clr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic signed [15:0] cf [8];
  always @(posedge clk) coef_data <= cf[coef_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint acc;
    int     edge_cyc;
  } exp_t;
  exp_t   exp_q[$];
  longint xh [3];
  longint yh [2];
  longint last_out = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     ready_mode = 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 3; i++) xh[i] = 0;
    for (int i = 0; i < 2; i++) yh[i] = 0;
  endtask

  // y[n] = sum b_k x[n-k] - sum a_k y[n-k], with y stored as floor(acc/2^13) clamped to 16 bits.
  task automatic model_accept(input longint s, input int edge_cyc);
    longint acc, q;
    exp_t e;
    xh[2] = xh[1]; xh[1] = xh[0]; xh[0] = s;
    acc = 0;
    for (int k = 0; k < 3; k++) acc += longint'(cf[k]) * xh[k];
    for (int j = 0; j < 2; j++) acc -= longint'(cf[3 + j]) * yh[j];
    q = acc / 8192;
    if ((acc % 8192) != 0 && acc < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    yh[1] = yh[0]; yh[0] = q;
    e.acc = acc;
    e.edge_cyc = edge_cyc;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic signed [7:0] s);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = s;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
      in_valid = 1'b0;
      return;
    end
    model_accept(longint'(s), cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int  n = 0;
    bit  done = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && in_ready && !out_valid;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: pending got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic set_cf(input int b0, input int b1, input int b2, input int a1, input int a2);
    cf[0] = 16'(b0); cf[1] = 16'(b1); cf[2] = 16'(b2); cf[3] = 16'(a1); cf[4] = 16'(a2);
  endtask

  // Consumer: out_ready changes just after the active edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on each new result, checks stability under stall and the post-handshake cycle.
  initial begin
    bit     ov_prev = 0, hs_prev = 0;
    longint held = 0;
    exp_t   e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        ov_prev = 0;
        hs_prev = 0;
      end else begin
        if (hs_prev) begin
          chk("post_hs_out_valid", longint'(out_valid), 0);
          chk("post_hs_in_ready", longint'(in_ready), 1);
        end
        if (out_valid && !ov_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_output: got data_out=%0d, required no output", data_out);
          end else begin
            e = exp_q.pop_front();
            chk("latency", longint'(cyc - e.edge_cyc), 7);
            chk("data_out", data_out, e.acc);
            last_out = data_out;
          end
        end else if (out_valid && ov_prev) begin
          chk("stall_stable", data_out, held);
        end
        hs_prev = out_valid && out_ready;
        ov_prev = out_valid;
        held    = data_out;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0; clr = 1'b0;
    for (int i = 0; i < 8; i++) cf[i] = '0;
    model_zero();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_coef_addr", longint'(coef_addr), 0);
    rst = 1'b0;

    // Passthrough
    ready_mode = 1;
    set_cf(8192, 0, 0, 0, 0);
    send(8'sh05);  wait_idle(); chk("pass_05", last_out, 40960);
    send(-8'sd6);  wait_idle(); chk("pass_fa", last_out, -49152);

    // Recursive impulse
    pulse_clr(); model_zero();
    set_cf(8192, 0, 0, -4096, 0);
    send(8'sd100); wait_idle(); chk("rec_0", last_out, 819200);
    send(8'sd0);   wait_idle(); chk("rec_1", last_out, 409600);
    send(8'sd0);   wait_idle(); chk("rec_2", last_out, 204800);
    send(8'sd0);   wait_idle(); chk("rec_3", last_out, 102400);

    // clr in IDLE clears, clr during RUN is ignored
    pulse_clr(); model_zero();
    send(8'sd0);   wait_idle(); chk("clr_idle", last_out, 0);
    send(8'sd100); wait_idle(); chk("clr_pre", last_out, 819200);
    send(8'sd0);   pulse_clr(); wait_idle(); chk("clr_in_run", last_out, 409600);

    // Backpressure: y history is 50 here
    ready_mode = 0;
    send(8'sd7);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      chk("bp_out_valid_seen", longint'(out_valid), 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      data_in  = 8'($urandom);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_busy", longint'(busy), 1);
    end
    @(negedge clk); in_valid = 1'b0;
    ready_mode = 1;
    wait_idle();
    chk("bp_result", last_out, 8192 * 7 + 4096 * 50);
    repeat (20) @(negedge clk);

    // Saturation of the y history
    pulse_clr(); model_zero();
    set_cf(32767, 0, 0, -8192, 0);
    for (int i = 0; i < 70; i++) send(-8'sd128);
    wait_idle();
    chk("sat_final", last_out, -272629632);

    // Reset three cycles into RUN
    set_cf(8192, 0, 0, -4096, 0);
    send(8'sh05);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_zero();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_busy", longint'(busy), 0);
    send(8'sh05); wait_idle(); chk("midrst_pass", last_out, 40960);

    // Randomized coefficients, samples, gaps and consumer stalls
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      wait_idle();
      for (int k = 0; k < 5; k++) cf[k] = 16'($urandom_range(0, 65535));
      if (r[0]) begin pulse_clr(); model_zero(); end
      for (int i = 0; i < 40; i++) begin
        send(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();
    ready_mode = 1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
